// File: rtl/vga_wq_pkg.sv
// vga_wq_pkg: shared FSM state, queue entry layout and frame-buffer geometry.
package vga_wq_pkg;
    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int PIXELS = H_RES * V_RES;
    localparam int ENTRY_ADDR_W = 19;
    localparam int ENTRY_DATA_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FILL} state_e;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/vga_wq_fifo.sv
// vga_wq_fifo: circular-buffer storage for pending pixel writes.
module vga_wq_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 27
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full_o  = count_q == (PW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign dout_o  = mem_q[head_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(pop_ok);
            tail_q  <= tail_q + PW'(push_ok);
            count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[tail_q] <= din_i;
    end
endmodule

// File: rtl/vga_write_queue.sv
// vga_write_queue: buffers processor pixel writes and streams them to the VGA frame buffer.
// Define VGA_WQ_FILL_EN to include the whole-frame fill engine.
module vga_write_queue
    import vga_wq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = ENTRY_ADDR_W,
    parameter int DATA_W = ENTRY_DATA_W,
    parameter int PIXELS = vga_wq_pkg::PIXELS
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              full_o,
    output logic              overflow_o,
    input  logic              fill_start_i,
    input  logic [DATA_W-1:0] fill_color_i,
    output logic              fill_busy_o,
    output logic              vga_wren_enable_o,
    output logic [ADDR_W-1:0] vga_data_addr_o,
    output logic [DATA_W-1:0] vga_data_write_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       count, count_d;
    logic                empty, push, pop, fill_go, fill_last;
    logic [ADDR_W-1:0]   fill_q, addr_d, head_addr;
    logic [DATA_W-1:0]   color_q, data_d, head_data;
    logic                wren_d, overflow_q;
    logic                wren_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;

    vga_wq_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
        .clk_i  (clock_i),
        .rst_i  (reset_i),
        .push_i (push),
        .pop_i  (pop),
        .din_i  ({wr_addr_i, wr_data_i}),
        .dout_o ({head_addr, head_data}),
        .count_o(count),
        .full_o (full_o),
        .empty_o(empty)
    );

    assign push = wr_en_i && !full_o;
    assign pop  = state_q != ST_FILL && !empty;
    assign count_d = count + CW'(push) - CW'(pop);

`ifdef VGA_WQ_FILL_EN
    assign fill_go   = fill_start_i && state_q != ST_FILL;
    assign fill_last = state_q == ST_FILL && fill_q == ADDR_W'(PIXELS - 1);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fill_q  <= '0;
            color_q <= '0;
        end else begin
            fill_q  <= (fill_go || fill_last) ? '0 : (state_q == ST_FILL) ? fill_q + 1'b1 : fill_q;
            color_q <= fill_go ? fill_color_i : color_q;
        end
    end
`else
    logic unused_fill;
    assign unused_fill = ^{fill_start_i, fill_color_i};
    assign fill_go   = 1'b0;
    assign fill_last = 1'b0;
    assign fill_q    = '0;
    assign color_q   = '0;
`endif

    // a fill request lets the pop issued this cycle complete before FILL begins
    always_comb begin
        state_d = fill_go ? ST_FILL
                : (state_q == ST_FILL && !fill_last) ? ST_FILL
                : (count_d != '0) ? ST_DRAIN : ST_IDLE;
        wren_d  = pop || state_q == ST_FILL;
        addr_d  = (state_q == ST_FILL) ? fill_q : head_addr;
        data_d  = (state_q == ST_FILL) ? color_q : head_data;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_q || (wr_en_i && full_o);
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign overflow_o        = overflow_q;
    assign fill_busy_o       = state_q == ST_FILL;
    assign vga_wren_enable_o = wren_q;
    assign vga_data_addr_o   = addr_q;
    assign vga_data_write_o  = data_q;
endmodule
